// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//   Sequential multi-precision adder. A WORDS x 16-bit addition is streamed
//   through one 16-bit carry-lookahead slice, least-significant word first,
//   one word per clock. The carry between words is held in a register, so
//   the combinational path is one slice deep for any WORDS.
//
//   Optional build macro: MWADD_SUB_EN adds the `sub` port (A - B mode).
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            request, sampled only in IDLE
//   a_in, b_in, cin  operands and carry-in, captured on accepted start
//   sub              subtract select (MWADD_SUB_EN builds only)
//   busy             high while words are being processed
//   done             one-cycle pulse, results valid from then on
//   sum_out, cout    W-bit result and carry out of the top word
//   ovf              two's-complement overflow of the W-bit result
//   all_prop         AND of slice Pm over all words
//
// State  | meaning
// IDLE   | waiting for start
// RUN    | one word per cycle through the slice
// DONE   | done pulse, back to IDLE next cycle

// 16-bit two-level carry-lookahead slice (4 groups of 4 bits).
module carry_ahead_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        Pm
);
    // Carries into bits 0..3 of a 4-bit group.
    function automatic logic [3:0] grp_carry(input logic [3:0] p, input logic [3:0] g,
                                             input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [3:0]  gc;

    always_comb begin
        p = a ^ b;
        g = a & b;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = grp_gen(p[4*k +: 4], g[4*k +: 4]);
        end
        gc = grp_carry(gp, gg, cin);
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k +: 4] = grp_carry(p[4*k +: 4], g[4*k +: 4], gc[k]);
        end
        sum  = p ^ c;
        cout = grp_gen(gp, gg) | ((&gp) & cin);
        Pm   = &p;
    end
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [16*WORDS-1:0] a_in,
    input  logic [16*WORDS-1:0] b_in,
    input  logic                cin,
`ifdef MWADD_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum_out,
    output logic                cout,
    output logic                ovf,
    output logic                all_prop
);
    localparam int W     = 16 * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [W-1:0]     a_q,        a_d;
    logic [W-1:0]     b_q,        b_d;
    logic             carry_q,    carry_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             prop_q,     prop_d;
    logic [W-1:0]     sum_out_q,  sum_out_d;
    logic             cout_q,     cout_d;
    logic             ovf_q,      ovf_d;
    logic             all_prop_q, all_prop_d;
`ifdef MWADD_SUB_EN
    logic             sub_q,      sub_d;
`endif

    logic [15:0] a_word;
    logic [15:0] b_eff;
    logic [15:0] slice_sum;
    logic        slice_cout;
    logic        slice_pm;

    assign a_word = a_q[16*idx_q +: 16];
`ifdef MWADD_SUB_EN
    assign b_eff  = sub_q ? ~b_q[16*idx_q +: 16] : b_q[16*idx_q +: 16];
`else
    assign b_eff  = b_q[16*idx_q +: 16];
`endif

    carry_ahead_adder16 u_slice (
        .a    (a_word),
        .b    (b_eff),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .Pm   (slice_pm)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        prop_d     = prop_q;
        sum_out_d  = sum_out_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        all_prop_d = all_prop_q;
`ifdef MWADD_SUB_EN
        sub_d      = sub_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    carry_d   = cin;
`ifdef MWADD_SUB_EN
                    sub_d     = sub;
                    // A - B = A + ~B + 1; the caller's cin is not used here.
                    if (sub) carry_d = 1'b1;
`endif
                    idx_d     = '0;
                    prop_d    = 1'b1;
                    sum_out_d = '0;
                    cout_d    = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                sum_out_d[16*idx_q +: 16] = slice_sum;
                carry_d = slice_cout;
                prop_d  = prop_q & slice_pm;
                if (idx_q == LAST) begin
                    cout_d     = slice_cout;
                    all_prop_d = prop_q & slice_pm;
                    ovf_d      = (a_word[15] ~^ b_eff[15]) & (slice_sum[15] ^ a_word[15]);
                    state_d    = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            prop_q     <= 1'b0;
            sum_out_q  <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            all_prop_q <= 1'b0;
`ifdef MWADD_SUB_EN
            sub_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            prop_q     <= prop_d;
            sum_out_q  <= sum_out_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            all_prop_q <= all_prop_d;
`ifdef MWADD_SUB_EN
            sub_q      <= sub_d;
`endif
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum_out  = sum_out_q;
    assign cout     = cout_q;
    assign ovf      = ovf_q;
    assign all_prop = all_prop_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with WORDS = 4.
module tb_multiword_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
`ifdef MWADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         ovf;
    logic         all_prop;

    int n_pass  = 0;
    int n_total = 0;
    int lat;
    int pulses;

    always #5 clk = ~clk;

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
`ifdef MWADD_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout     (cout),
        .ovf      (ovf),
        .all_prop (all_prop)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (caller is at posedge+#1), wait for done with a bound.
    // lat counts edges from the accepting edge to the edge that raises done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb, output int latency);
        a_in  = a;
        b_in  = b;
        cin   = ci;
`ifdef MWADD_SUB_EN
        sub   = sb;
`else
        if (sb) $display("note: subtract requested in add-only build");
`endif
        start = 1'b1;
        latency = 99;
        for (int i = 1; i <= 20; i++) begin
            step();
            start = 1'b0;
            if (i == 1) chk("busy_after_start", {63'd0, busy}, 64'd1);
            if (done) begin
                latency = i;
                break;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
`ifdef MWADD_SUB_EN
        sub   = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        chk("rst_busy",     {63'd0, busy},     64'd0);
        chk("rst_done",     {63'd0, done},     64'd0);
        chk("rst_sum",      sum_out,           64'd0);
        chk("rst_cout",     {63'd0, cout},     64'd0);
        chk("rst_ovf",      {63'd0, ovf},      64'd0);
        chk("rst_all_prop", {63'd0, all_prop}, 64'd0);

        // Full carry ripple through every word.
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, lat);
        chk("t1_latency",  64'(lat),          64'd5);
        chk("t1_sum",      sum_out,           64'd0);
        chk("t1_cout",     {63'd0, cout},     64'd1);
        chk("t1_all_prop", {63'd0, all_prop}, 64'd1);
        chk("t1_ovf",      {63'd0, ovf},      64'd0);
        step();
        chk("t1_done_one_cycle", {63'd0, done}, 64'd0);
        chk("t1_sum_hold", sum_out, 64'd0);

        do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, lat);
        chk("t2_latency",  64'(lat),          64'd5);
        chk("t2_sum",      sum_out,           64'h0000_0000_0001_0000);
        chk("t2_cout",     {63'd0, cout},     64'd0);
        chk("t2_ovf",      {63'd0, ovf},      64'd0);
        chk("t2_all_prop", {63'd0, all_prop}, 64'd0);
        step();

        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
        chk("t3_sum",  sum_out,       64'h8000_0000_0000_0000);
        chk("t3_ovf",  {63'd0, ovf},  64'd1);
        chk("t3_cout", {63'd0, cout}, 64'd0);
        step();

        // Negative overflow with carry out.
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, lat);
        chk("t4_sum",  sum_out,       64'd0);
        chk("t4_cout", {63'd0, cout}, 64'd1);
        chk("t4_ovf",  {63'd0, ovf},  64'd1);
        step();

        do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0, lat);
        chk("t5_sum",      sum_out,           64'h2345_6789_ABCD_F002);
        chk("t5_cout",     {63'd0, cout},     64'd0);
        chk("t5_ovf",      {63'd0, ovf},      64'd0);
        chk("t5_all_prop", {63'd0, all_prop}, 64'd0);
        step();

        // Reset during the second RUN cycle.
        a_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        b_in  = 64'd0;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_sum",  sum_out,       64'd0);
        chk("rst_mid_cout", {63'd0, cout}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            if (i < 7) step();
        end
        chk("rst_mid_no_done", 64'(pulses), 64'd0);
        do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, lat);
        chk("rst_after_latency", 64'(lat), 64'd5);
        chk("rst_after_sum",     sum_out,  64'h0000_0000_0001_0000);
        step();

        // start held through RUN and DONE: one operation only.
        a_in  = 64'h0000_0000_0000_0003;
        b_in  = 64'h0000_0000_0000_0004;
        cin   = 1'b0;
        start = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 5) start = 1'b0;
            if (done) pulses++;
            if (i == 3) a_in = 64'h0000_0000_0000_0100;
            if (i == 8) chk("held_sum_stable_a", sum_out, 64'd7);
        end
        chk("held_done_once", 64'(pulses), 64'd1);
        chk("held_sum_stable_b", sum_out, 64'd7);
        chk("held_busy_idle", {63'd0, busy}, 64'd0);

        do_op(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0004, 1'b0, 1'b0, lat);
        chk("held_next_sum", sum_out, 64'h0000_0000_0000_0104);
        step();

`ifdef MWADD_SUB_EN
        do_op(64'd5, 64'd7, 1'b0, 1'b1, lat);
        chk("sub_sum",  sum_out,       64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_cout", {63'd0, cout}, 64'd0);
        chk("sub_ovf",  {63'd0, ovf},  64'd0);
        step();
        do_op(64'd7, 64'd5, 1'b0, 1'b1, lat);
        chk("sub2_sum",  sum_out,       64'd2);
        chk("sub2_cout", {63'd0, cout}, 64'd1);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
